// File: rtl/ps2_kb_writer_pkg.sv
// Shared scan-code constants, event-word layout and receiver state type for the
// PS/2 keyboard writer.
package kb_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    localparam int EW_ASCII_LSB = 0;
    localparam int EW_CODE_LSB  = 8;
    localparam int EW_MAKE      = 16;
    localparam int EW_EXT       = 17;
    localparam int EW_SHIFT     = 18;
    localparam int EW_CAPS      = 19;
    localparam int EW_CTRL      = 20;
    localparam int EW_SEQ_LSB   = 24;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_e;

    // Controller responses and self-test codes that never describe a key.
    function automatic logic is_discard(input logic [7:0] code);
        return (code == 8'h00) || (code == 8'hAA) || (code == 8'hE1) ||
               (code == 8'hFA) || (code == 8'hFE) || (code == 8'hFF);
    endfunction

    function automatic logic is_modifier(input logic [7:0] code);
        return (code == SC_LSHIFT) || (code == SC_RSHIFT) ||
               (code == SC_CTRL)   || (code == SC_CAPS);
    endfunction

endpackage

// File: rtl/ps2_kb_writer_if.sv
// Write port toward the KB_INFO region plus the discarded-frame error pulse.
interface ps2_kb_writer_if;

    logic [31:0] kb_wraddr;
    logic [31:0] kb_wrdata;
    logic        kb_we;
    logic        kb_err;

    modport master (
        output kb_wraddr,
        output kb_wrdata,
        output kb_we,
        output kb_err
    );

    modport slave (
        input kb_wraddr,
        input kb_wrdata,
        input kb_we,
        input kb_err
    );

endinterface

// File: rtl/ps2_scan2ascii.sv
// Combinational scan-code set 2 to ASCII lookup; letters use shift XOR caps,
// all other keys use shift alone. Unknown codes map to 0.
module ps2_scan2ascii (
    input  logic [7:0] code_i,
    input  logic       shift_i,
    input  logic       caps_i,
    output logic [7:0] ascii_o
);

    logic [7:0] lower;
    logic [7:0] upper;
    logic       letter;

    always_comb begin
        lower = 8'h00;
        upper = 8'h00;
        case (code_i)
            8'h1C: lower = "a";  8'h32: lower = "b";  8'h21: lower = "c";
            8'h23: lower = "d";  8'h24: lower = "e";  8'h2B: lower = "f";
            8'h34: lower = "g";  8'h33: lower = "h";  8'h43: lower = "i";
            8'h3B: lower = "j";  8'h42: lower = "k";  8'h4B: lower = "l";
            8'h3A: lower = "m";  8'h31: lower = "n";  8'h44: lower = "o";
            8'h4D: lower = "p";  8'h15: lower = "q";  8'h2D: lower = "r";
            8'h1B: lower = "s";  8'h2C: lower = "t";  8'h3C: lower = "u";
            8'h2A: lower = "v";  8'h1D: lower = "w";  8'h22: lower = "x";
            8'h35: lower = "y";  8'h1A: lower = "z";
            8'h45: {lower, upper} = {"0", ")"};
            8'h16: {lower, upper} = {"1", "!"};
            8'h1E: {lower, upper} = {"2", "@"};
            8'h26: {lower, upper} = {"3", "#"};
            8'h25: {lower, upper} = {"4", "$"};
            8'h2E: {lower, upper} = {"5", "%"};
            8'h36: {lower, upper} = {"6", "^"};
            8'h3D: {lower, upper} = {"7", "&"};
            8'h3E: {lower, upper} = {"8", "*"};
            8'h46: {lower, upper} = {"9", "("};
            8'h0E: {lower, upper} = {8'h60, "~"};
            8'h4E: {lower, upper} = {"-", "_"};
            8'h55: {lower, upper} = {"=", "+"};
            8'h54: {lower, upper} = {"[", "{"};
            8'h5B: {lower, upper} = {"]", "}"};
            8'h5D: {lower, upper} = {"\\", "|"};
            8'h4C: {lower, upper} = {";", ":"};
            8'h52: {lower, upper} = {"'", "\""};
            8'h41: {lower, upper} = {",", "<"};
            8'h49: {lower, upper} = {".", ">"};
            8'h4A: {lower, upper} = {"/", "?"};
            8'h29: {lower, upper} = {8'h20, 8'h20};
            8'h5A: {lower, upper} = {8'h0A, 8'h0A};
            8'h66: {lower, upper} = {8'h08, 8'h08};
            default: begin
                lower = 8'h00;
                upper = 8'h00;
            end
        endcase
        letter = (lower >= "a") && (lower <= "z");
        if (letter) begin
            upper = lower - 8'h20;
        end
    end

    always_comb begin
        if (letter) begin
            ascii_o = (shift_i ^ caps_i) ? upper : lower;
        end else begin
            ascii_o = shift_i ? upper : lower;
        end
    end

endmodule

// File: rtl/ps2_kb_writer.sv
// PS/2 keyboard receiver and event decoder that writes one packed event word per key
// event to KB_INFO. Define KB_ASCII_EN to compile in the scan-to-ASCII lookup.
module ps2_kb_writer
    import kb_pkg::*;
#(
    parameter logic [31:0] KB_INFO_ADDR   = 32'h0050_0000,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    ps2_kb_writer_if.master  kb_if
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [2:0]      clk_sync_q;
    logic [2:0]      dat_sync_q;
    logic            clk_prev_q;
    logic            fall;
    logic            bit_in;

    rx_state_e       state_q, state_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_hit;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shreg_q;
    logic            par_q;
    logic            shift_en;
    logic            par_en;
    logic            frame_ok;
    logic            rx_err;

    logic            byte_vld_q;
    logic [7:0]      byte_q;
    logic            err_q;

    logic            ext_pend_q, ext_pend_d;
    logic            brk_pend_q, brk_pend_d;
    logic            shift_q, shift_d;
    logic            ctrl_q, ctrl_d;
    logic            caps_q, caps_d;
    logic [7:0]      seq_q, seq_d;
    logic            event_p1;
    logic [7:0]      ascii_p1;
    logic [31:0]     word_p1;

    logic            kb_we_q;
    logic            kb_err_q;
    logic [31:0]     kb_wrdata_q;

    // Synchronizers idle high so reset never fabricates a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q <= 3'b111;
            dat_sync_q <= 3'b111;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[1:0], ps2_clk};
            dat_sync_q <= {dat_sync_q[1:0], ps2_data};
            clk_prev_q <= clk_sync_q[2];
        end
    end

    assign fall   = clk_prev_q & ~clk_sync_q[2];
    assign bit_in = dat_sync_q[2];

    assign to_cnt_d    = (fall || state_q == RX_IDLE) ? '0 : to_cnt_q + 1'b1;
    assign timeout_hit = (state_q != RX_IDLE) && !fall &&
                         (to_cnt_q == TO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RX_IDLE;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (timeout_hit) begin
            state_d = RX_IDLE;
        end else if (fall) begin
            case (state_q)
                RX_IDLE:   if (!bit_in) state_d = RX_DATA;
                RX_DATA:   if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
                RX_PARITY: state_d = RX_STOP;
                RX_STOP:   state_d = RX_IDLE;
                default:   state_d = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        shift_en = fall && (state_q == RX_DATA);
        par_en   = fall && (state_q == RX_PARITY);
        frame_ok = fall && (state_q == RX_STOP) && bit_in && (^{shreg_q, par_q});
        rx_err   = timeout_hit || (fall && (state_q == RX_STOP) && !frame_ok);
    end

    always_ff @(posedge clk) begin
        if (rst || state_q == RX_IDLE) begin
            bit_cnt_q <= 3'd0;
        end else if (shift_en) begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (shift_en) shreg_q <= {bit_in, shreg_q[7:1]};
        if (par_en)   par_q   <= bit_in;
    end

    // Stage p1: received byte (or frame error) valid one cycle after the stop edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_vld_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            byte_vld_q <= frame_ok;
            err_q      <= rx_err;
        end
    end

    always_ff @(posedge clk) begin
        if (frame_ok) byte_q <= shreg_q;
    end

    always_comb begin
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        shift_d    = shift_q;
        ctrl_d     = ctrl_q;
        caps_d     = caps_q;
        seq_d      = seq_q;
        event_p1   = 1'b0;
        if (byte_vld_q) begin
            if (byte_q == SC_EXT) begin
                ext_pend_d = 1'b1;
            end else if (byte_q == SC_BREAK) begin
                brk_pend_d = 1'b1;
            end else begin
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
                if (!is_discard(byte_q)) begin
                    event_p1 = 1'b1;
                    seq_d    = seq_q + 8'd1;
                    if (!ext_pend_q && (byte_q == SC_LSHIFT || byte_q == SC_RSHIFT)) begin
                        shift_d = ~brk_pend_q;
                    end
                    if (byte_q == SC_CTRL) begin
                        ctrl_d = ~brk_pend_q;
                    end
                    if (byte_q == SC_CAPS && !brk_pend_q) begin
                        caps_d = ~caps_q;
                    end
                end
            end
        end
    end

`ifdef KB_ASCII_EN
    logic [7:0] lut_ascii;

    // Looked up with the post-update modifiers so a modifier key affects its own word.
    ps2_scan2ascii u_scan2ascii (
        .code_i  (byte_q),
        .shift_i (shift_d),
        .caps_i  (caps_d),
        .ascii_o (lut_ascii)
    );

    assign ascii_p1 = (ext_pend_q || is_modifier(byte_q)) ? 8'h00 : lut_ascii;
`else
    assign ascii_p1 = 8'h00;
`endif

    always_comb begin
        word_p1                       = '0;
        word_p1[EW_ASCII_LSB +: 8]    = ascii_p1;
        word_p1[EW_CODE_LSB +: 8]     = byte_q;
        word_p1[EW_MAKE]              = ~brk_pend_q;
        word_p1[EW_EXT]               = ext_pend_q;
        word_p1[EW_SHIFT]             = shift_d;
        word_p1[EW_CAPS]              = caps_d;
        word_p1[EW_CTRL]              = ctrl_d;
        word_p1[EW_SEQ_LSB +: 8]      = seq_d;
    end

    // Stage p2: decoder state and the registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            shift_q     <= 1'b0;
            ctrl_q      <= 1'b0;
            caps_q      <= 1'b0;
            seq_q       <= 8'h00;
            kb_we_q     <= 1'b0;
            kb_err_q    <= 1'b0;
            kb_wrdata_q <= '0;
        end else begin
            ext_pend_q <= ext_pend_d;
            brk_pend_q <= brk_pend_d;
            shift_q    <= shift_d;
            ctrl_q     <= ctrl_d;
            caps_q     <= caps_d;
            seq_q      <= seq_d;
            kb_we_q    <= event_p1;
            kb_err_q   <= err_q;
            if (event_p1) kb_wrdata_q <= word_p1;
        end
    end

    assign kb_if.kb_wraddr = KB_INFO_ADDR;
    assign kb_if.kb_wrdata = kb_wrdata_q;
    assign kb_if.kb_we     = kb_we_q;
    assign kb_if.kb_err    = kb_err_q;

endmodule

// File: tb/tb_ps2_kb_writer.sv
// Scoreboard bench for ps2_kb_writer: directed PS/2 frames push expected words,
// a negedge monitor pops and compares every kb_we / kb_err pulse.
module tb_ps2_kb_writer;

    localparam int TO_CYC = 300;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_wr[$];
    int exp_err = 0;
    logic [31:0] last_wr = 32'h0;

    ps2_kb_writer_if kb_bus ();

    ps2_kb_writer #(
        .KB_INFO_ADDR   (32'h0050_0000),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .kb_if    (kb_bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] asc(input logic [7:0] v);
`ifdef KB_ASCII_EN
        return v;
`else
        return 8'h00 & v;
`endif
    endfunction

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        logic [31:0] want;
        if (kb_bus.kb_we === 1'b1) begin
            checks++;
            if (exp_wr.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write got=%h want=none", kb_bus.kb_wrdata);
            end else begin
                want = exp_wr.pop_front();
                if (kb_bus.kb_wrdata !== want) begin
                    failures++;
                    $display("FAIL write_word got=%h want=%h", kb_bus.kb_wrdata, want);
                end
            end
        end
        if (kb_bus.kb_err === 1'b1) begin
            checks++;
            if (exp_err == 0) begin
                failures++;
                $display("FAIL unexpected_err got=1 want=0");
            end else begin
                exp_err--;
            end
        end
    end

    task automatic ps2_send(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            repeat (5) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (10) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (5) @(negedge clk);
        end
        ps2_data = 1'b1;
        repeat (30) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        ps2_send(b, 1'b0, 11);
    endtask

    task automatic expect_wr(input logic [31:0] w);
        exp_wr.push_back(w);
        last_wr = w;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_wr.size() != 0 || exp_err != 0) begin
            failures++;
            $display("FAIL %s_drained got_pending_wr=%0d pending_err=%0d want=0",
                     name, exp_wr.size(), exp_err);
        end
        exp_wr.delete();
        exp_err = 0;
        checks++;
        if (kb_bus.kb_wrdata !== last_wr) begin
            failures++;
            $display("FAIL %s_hold got=%h want=%h", name, kb_bus.kb_wrdata, last_wr);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    initial begin
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("reset_we",     {31'h0, kb_bus.kb_we},  32'h0);
        check_val("reset_err",    {31'h0, kb_bus.kb_err}, 32'h0);
        check_val("reset_wrdata", kb_bus.kb_wrdata,       32'h0);
        check_val("wraddr",       kb_bus.kb_wraddr,       32'h0050_0000);

        // Plain key, ACK discard, then a break of the same key.
        expect_wr({24'h01011C, asc(8'h61)});
        send_byte(8'h1C);
        send_byte(8'hFA);
        expect_wr({24'h02011C, asc(8'h61)});
        send_byte(8'h1C);
        expect_wr({24'h03001C, asc(8'h61)});
        send_byte(8'hF0);
        send_byte(8'h1C);
        check_drained("plain");

        do_reset();
        expect_wr(32'h0105_1200);
        expect_wr({24'h02051C, asc(8'h41)});
        send_byte(8'h12);
        send_byte(8'h1C);
        check_drained("shift");

        do_reset();
        expect_wr(32'h0109_5800);
        expect_wr(32'h0208_5800);
        expect_wr({24'h03091C, asc(8'h41)});
        send_byte(8'h58);
        send_byte(8'hF0);
        send_byte(8'h58);
        send_byte(8'h1C);
        check_drained("caps");

        do_reset();
        expect_wr(32'h0103_7500);
        send_byte(8'hE0);
        send_byte(8'h75);
        expect_wr(32'h0202_7500);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        check_drained("ext");

        do_reset();
        exp_err++;
        ps2_send(8'h1C, 1'b1, 11);
        expect_wr({24'h01011C, asc(8'h61)});
        send_byte(8'h1C);
        check_drained("parity");

        exp_err++;
        ps2_send(8'h1C, 1'b0, 5);
        repeat (TO_CYC + 50) @(negedge clk);
        expect_wr({24'h02011C, asc(8'h61)});
        send_byte(8'h1C);
        check_drained("timeout");

        ps2_send(8'h1C, 1'b0, 5);
        do_reset();
        last_wr = 32'h0;
        expect_wr({24'h01011C, asc(8'h61)});
        send_byte(8'h1C);
        check_drained("midreset");
        check_val("wraddr_end", kb_bus.kb_wraddr, 32'h0050_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
